// File: rtl/table_seq_pkg.sv
// rtl/table_seq_pkg.sv - shared types and limits for the table address sequencer
package table_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int max_read_lat = 7;

    typedef logic [2:0] lat_cnt_t;

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - shift register delaying a valid flag by depth cycles
module valid_delay_line #(
    parameter int depth = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic valid,
    output logic delayed
);

    generate
        if (depth == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, rst, flush};
            assign delayed   = valid;
        end else begin : g_shift
            logic [depth-1:0] sr;
            logic [depth:0]   sr_ext;

            assign sr_ext = {sr, valid};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else if (flush) begin
                    sr <= '0;
                end else begin
                    sr <= sr_ext[depth-1:0];
                end
            end

            assign delayed = sr[depth-1];
        end
    endgenerate

endmodule

// File: rtl/table_addr_sequencer.sv
// rtl/table_addr_sequencer.sv - sweeps a table address range and flags when table outputs are valid
module table_addr_sequencer
    import table_seq_pkg::*;
#(
    parameter int addr_bits = 1,
    parameter int read_lat  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 loop,
    input  logic [addr_bits-1:0] first_addr,
    input  logic [addr_bits-1:0] last_addr,
    input  logic [addr_bits-1:0] step,
    output logic [addr_bits-1:0] addr,
    output logic                 addr_valid,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int       lat_clamped = (read_lat > max_read_lat) ? max_read_lat : read_lat;
    localparam lat_cnt_t drain_init  = (lat_clamped == 0) ? lat_cnt_t'(0) : lat_cnt_t'(lat_clamped - 1);

    seq_state_t           state, state_n;
    logic [addr_bits-1:0] addr_n, first_q, last_q, step_q;
    logic                 loop_q, addr_valid_n, latch, flush;
    lat_cnt_t             cnt, cnt_n;
    logic [addr_bits:0]   sum;
    logic                 wrap;

    // Carry bit catches strides that overflow the address width.
    assign sum  = {1'b0, addr} + {1'b0, step_q};
    assign wrap = sum[addr_bits] || (sum[addr_bits-1:0] > last_q);

    always_comb begin
        state_n      = state;
        addr_n       = addr;
        addr_valid_n = addr_valid;
        cnt_n        = cnt;
        latch        = 1'b0;
        flush        = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    latch        = 1'b1;
                    addr_n       = first_addr;
                    addr_valid_n = 1'b1;
                    state_n      = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n      = IDLE;
                    addr_valid_n = 1'b0;
                    flush        = 1'b1;
                end else if (wrap) begin
                    if (loop_q) begin
                        addr_n = first_q;
                    end else begin
                        addr_valid_n = 1'b0;
                        if (lat_clamped == 0) begin
                            done    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = DRAIN;
                            cnt_n   = drain_init;
                        end
                    end
                end else begin
                    addr_n = sum[addr_bits-1:0];
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if (cnt == '0) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
            first_q    <= '0;
            last_q     <= '0;
            step_q     <= '0;
            loop_q     <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            addr_valid <= addr_valid_n;
            busy       <= (state_n != IDLE);
            cnt        <= cnt_n;
            if (latch) begin
                first_q <= first_addr;
                last_q  <= last_addr;
                step_q  <= (step == '0) ? addr_bits'(1) : step;
                loop_q  <= loop;
            end
        end
    end

    valid_delay_line #(
        .depth(lat_clamped)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .valid  (addr_valid),
        .delayed(out_valid)
    );

endmodule

// File: tb/tb_table_addr_sequencer.sv
// tb/tb_table_addr_sequencer.sv - bench for table_addr_sequencer at read latencies 0, 1 and 3
module tb_table_addr_sequencer;

    localparam int NCYC = 2048;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    logic       clk = 1'b0;
    logic       rst, start, abort, loop;
    logic [2:0] first_addr, last_addr, step;
    logic [2:0] addr_o [3];
    logic       av_o   [3];
    logic       ov_o   [3];
    logic       busy_o [3];
    logic       done_o [3];

    always #5 clk = ~clk;

    table_addr_sequencer #(.addr_bits(3), .read_lat(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
        .first_addr(first_addr), .last_addr(last_addr), .step(step),
        .addr(addr_o[0]), .addr_valid(av_o[0]), .out_valid(ov_o[0]),
        .busy(busy_o[0]), .done(done_o[0]));

    table_addr_sequencer #(.addr_bits(3), .read_lat(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
        .first_addr(first_addr), .last_addr(last_addr), .step(step),
        .addr(addr_o[1]), .addr_valid(av_o[1]), .out_valid(ov_o[1]),
        .busy(busy_o[1]), .done(done_o[1]));

    table_addr_sequencer #(.addr_bits(3), .read_lat(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
        .first_addr(first_addr), .last_addr(last_addr), .step(step),
        .addr(addr_o[2]), .addr_valid(av_o[2]), .out_valid(ov_o[2]),
        .busy(busy_o[2]), .done(done_o[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a sweep is the list of addresses first + k*step (k >= 0) not above last,
    // always containing first; out_valid is the addr_valid history shifted by the latency.
    int  m_seq [3][$];
    int  m_addr [3], m_idx [3], drain_end [3], flush_t [3];
    bit  m_busy [3], m_av [3], m_loop [3];
    bit  av_h [3][NCYC];
    bit  last_h [3][NCYC];
    int  t = 0;
    int  cap_q [$];
    int  last_av_t [3], done_t [3], done_cnt [3];

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_seq[d].delete();
            m_addr[d] = 0; m_idx[d] = 0; drain_end[d] = -1; flush_t[d] = -1;
            m_busy[d] = 0; m_av[d] = 0; m_loop[d] = 0;
            for (int i = 0; i < NCYC; i++) begin
                av_h[d][i]   = 0;
                last_h[d][i] = 0;
            end
        end
    endtask

    task automatic model_advance(input int d);
        int a, se;
        if (m_busy[d] && abort) begin
            flush_t[d] = t;
            m_busy[d]  = 0;
            m_av[d]    = 0;
        end else if (!m_busy[d]) begin
            if (start && !abort) begin
                se = (step == 0) ? 1 : int'(step);
                m_seq[d].delete();
                a = int'(first_addr);
                do begin
                    m_seq[d].push_back(a);
                    a += se;
                end while (a <= int'(last_addr));
                m_idx[d]  = 0;
                m_addr[d] = m_seq[d][0];
                m_av[d]   = 1;
                m_busy[d] = 1;
                m_loop[d] = loop;
            end
        end else if (m_av[d]) begin
            if (m_idx[d] + 1 < m_seq[d].size()) begin
                m_idx[d]++;
                m_addr[d] = m_seq[d][m_idx[d]];
            end else if (m_loop[d]) begin
                m_idx[d]  = 0;
                m_addr[d] = m_seq[d][0];
            end else begin
                m_av[d]      = 0;
                drain_end[d] = t + lat_of(d);
                m_busy[d]    = (t + 1 <= drain_end[d]);
            end
        end else begin
            m_busy[d] = (t + 1 <= drain_end[d]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else if (t < NCYC) begin
            for (int d = 0; d < 3; d++) begin
                int src, L;
                bit e_ov, e_done;
                L = lat_of(d);
                av_h[d][t]   = m_av[d];
                last_h[d][t] = m_av[d] && !m_loop[d] && (m_idx[d] == m_seq[d].size() - 1);
                src    = t - L;
                e_ov   = (src >= 0) && av_h[d][src] && !(src <= flush_t[d] && flush_t[d] < t);
                e_done = e_ov && last_h[d][src] && !abort;
                chk($sformatf("addr lat%0d t%0d", L, t), 32'(addr_o[d]), 32'(m_addr[d]));
                chk($sformatf("addr_valid lat%0d t%0d", L, t), 32'(av_o[d]), 32'(m_av[d]));
                chk($sformatf("out_valid lat%0d t%0d", L, t), 32'(ov_o[d]), 32'(e_ov));
                chk($sformatf("busy lat%0d t%0d", L, t), 32'(busy_o[d]), 32'(m_busy[d]));
                chk($sformatf("done lat%0d t%0d", L, t), 32'(done_o[d]), 32'(e_done));
                if (d == 1 && av_o[1] === 1'b1) cap_q.push_back(int'(addr_o[1]));
                if (av_o[d] === 1'b1) last_av_t[d] = t;
                if (done_o[d] === 1'b1) begin
                    done_t[d] = t;
                    done_cnt[d]++;
                end
                model_advance(d);
            end
            t++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o[0] | busy_o[1] | busy_o[2]) && n < 100) begin
            tick();
            n++;
        end
        chk({name, " idle_timeout"}, 32'(n < 100), 32'd1);
    endtask

    task automatic sweep(input string name, input int f, input int l, input int s, input int ex [$]);
        int base, n;
        int dc [3];
        wait_idle(name);
        base = cap_q.size();
        for (int d = 0; d < 3; d++) dc[d] = done_cnt[d];
        tick();
        first_addr = 3'(f); last_addr = 3'(l); step = 3'(s); loop = 1'b0; start = 1'b1;
        tick();
        n = 0;
        while (done_cnt[2] == dc[2] && n < 60) begin
            tick();
            n++;
        end
        @(negedge clk);
        #1;
        chk({name, " n_addr"}, 32'(cap_q.size() - base), 32'(ex.size()));
        for (int i = 0; i < ex.size(); i++) begin
            if (base + i < cap_q.size())
                chk($sformatf("%s addr[%0d]", name, i), 32'(cap_q[base + i]), 32'(ex[i]));
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s done_count lat%0d", name, lat_of(d)), 32'(done_cnt[d] - dc[d]), 32'd1);
            chk($sformatf("%s done_gap lat%0d", name, lat_of(d)), 32'(done_t[d] - last_av_t[d]), 32'(lat_of(d)));
        end
    endtask

    initial begin
        int ex [$];
        int base, n;
        int dc [3];
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
        first_addr = '0; last_addr = '0; step = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset addr", 32'(addr_o[d]), 32'd0);
            chk("reset addr_valid", 32'(av_o[d]), 32'd0);
            chk("reset out_valid", 32'(ov_o[d]), 32'd0);
            chk("reset busy", 32'(busy_o[d]), 32'd0);
            chk("reset done", 32'(done_o[d]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        ex = {0, 1, 2, 3, 4, 5, 6, 7};
        sweep("full", 0, 7, 1, ex);
        ex = {1, 3, 5};
        sweep("stride2", 1, 6, 2, ex);
        ex = {6};
        sweep("carry", 6, 7, 3, ex);
        ex = {5};
        sweep("inverted", 5, 2, 1, ex);
        ex = {2, 3, 4};
        sweep("step0", 2, 4, 0, ex);

        // Looping sweep: a second start mid-sweep must be ignored, abort at the second visit of 3.
        wait_idle("loop");
        base = cap_q.size();
        for (int d = 0; d < 3; d++) dc[d] = done_cnt[d];
        tick();
        first_addr = 3'd2; last_addr = 3'd4; step = 3'd1; loop = 1'b1; start = 1'b1;
        tick();
        n = 0;
        while (n < 20) begin
            if (n == 2) begin
                start = 1'b1;
                first_addr = 3'd0;
                last_addr = 3'd7;
            end
            if (av_o[1] && addr_o[1] == 3'd3 && cap_q.size() - base >= 4) begin
                abort = 1'b1;
                break;
            end
            tick();
            n++;
        end
        chk("loop abort_reached", 32'(n < 20), 32'd1);
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("abort addr_valid", 32'(av_o[d]), 32'd0);
            chk("abort out_valid", 32'(ov_o[d]), 32'd0);
            chk("abort busy", 32'(busy_o[d]), 32'd0);
            chk("abort addr_hold", 32'(addr_o[d]), 32'd3);
        end
        @(negedge clk);
        #1;
        ex = {2, 3, 4, 2, 3};
        chk("loop n_addr", 32'(cap_q.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (base + i < cap_q.size())
                chk($sformatf("loop addr[%0d]", i), 32'(cap_q[base + i]), 32'(ex[i]));
        for (int d = 0; d < 3; d++)
            chk("loop no_done", 32'(done_cnt[d] - dc[d]), 32'd0);

        // Asynchronous reset in the middle of a sweep.
        tick();
        first_addr = 3'd0; last_addr = 3'd7; step = 3'd1; loop = 1'b0; start = 1'b1;
        repeat (4) tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_rst addr", 32'(addr_o[d]), 32'd0);
            chk("async_rst addr_valid", 32'(av_o[d]), 32'd0);
            chk("async_rst out_valid", 32'(ov_o[d]), 32'd0);
            chk("async_rst busy", 32'(busy_o[d]), 32'd0);
            chk("async_rst done", 32'(done_o[d]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ex = {0, 1, 2, 3, 4, 5, 6, 7};
        sweep("after_rst", 0, 7, 1, ex);

        // Random traffic checked against the model every cycle.
        for (int i = 0; i < 500; i++) begin
            tick();
            start      = ($urandom % 6) == 0;
            abort      = ($urandom % 40) == 0;
            loop       = ($urandom % 4) == 0;
            first_addr = 3'($urandom);
            last_addr  = 3'($urandom);
            step       = 3'($urandom);
        end
        tick();
        abort = 1'b1;
        tick();
        wait_idle("final");
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
